// File: rtl/branch_predictor_gshare.sv
// Table of 2-bit saturating counters, swept to weakly-not-taken after reset.
// Define PREDICTOR_GSHARE_EN for global-history XOR indexing; otherwise bimodal.
module branch_predictor_gshare #(
    parameter int PC_W    = 15,
    parameter int INDEX_W = 10,
    parameter int HIST_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pred_en,
    input  logic [PC_W-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            rslt_en,
    input  logic [PC_W-1:0] rslt_pc,
    input  logic            rslt_taken,
    output logic            init_done
);
    localparam int DEPTH = 1 << INDEX_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state;
    state_t             state_next;
    logic [INDEX_W-1:0] ptr;
    logic [1:0]         counters [DEPTH];
    logic [INDEX_W-1:0] pred_idx;
    logic [INDEX_W-1:0] rslt_idx;
    logic [1:0]         rslt_cnt;
    logic [1:0]         rslt_cnt_next;
    logic               upd_en;

    generate
        if (INDEX_W > PC_W || HIST_W < 1 || HIST_W > INDEX_W) begin : g_bad_params
            $error("branch_predictor_gshare: illegal INDEX_W/HIST_W");
        end
    endgenerate

    assign upd_en = (state == RUN) && rslt_en && !reset;

`ifdef PREDICTOR_GSHARE_EN
    logic [HIST_W-1:0]  ghr;
    logic [INDEX_W-1:0] hist;

    assign hist = INDEX_W'(ghr);

    // History is shifted only by resolved outcomes, after indexing with the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr <= '0;
        end else if (upd_en) begin
            ghr <= (ghr << 1) | HIST_W'(rslt_taken);
        end
    end

    assign pred_idx = INDEX_W'(pred_pc) ^ hist;
    assign rslt_idx = INDEX_W'(rslt_pc) ^ hist;
`else
    assign pred_idx = INDEX_W'(pred_pc);
    assign rslt_idx = INDEX_W'(rslt_pc);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                ptr <= ptr + INDEX_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            INIT:    if (ptr == '1) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    assign rslt_cnt = counters[rslt_idx];

    always_comb begin
        rslt_cnt_next = rslt_cnt;
        if (rslt_taken) begin
            if (rslt_cnt != 2'b11) rslt_cnt_next = rslt_cnt + 2'b01;
        end else begin
            if (rslt_cnt != 2'b00) rslt_cnt_next = rslt_cnt - 2'b01;
        end
    end

    // Table has no reset; the sweep establishes its contents.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            counters[ptr] <= 2'b01;
        end else if (upd_en) begin
            counters[rslt_idx] <= rslt_cnt_next;
        end
    end

    assign pred_taken = (state == RUN) && pred_en && counters[pred_idx][1];
    assign init_done  = (state == RUN);

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed self-checking bench for branch_predictor_gshare (default parameters).
// Bimodal checks in the default build; gshare checks when PREDICTOR_GSHARE_EN is defined.
module tb_branch_predictor_gshare;
    localparam int SWEEP = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        pred_en;
    logic [14:0] pred_pc;
    logic        pred_taken;
    logic        rslt_en;
    logic [14:0] rslt_pc;
    logic        rslt_taken;
    logic        init_done;

    int errors = 0;
    int checks = 0;

    branch_predictor_gshare dut (
        .clk        (clk),
        .reset      (reset),
        .pred_en    (pred_en),
        .pred_pc    (pred_pc),
        .pred_taken (pred_taken),
        .rslt_en    (rslt_en),
        .rslt_pc    (rslt_pc),
        .rslt_taken (rslt_taken),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic update(input logic [14:0] pc, input logic t);
        rslt_en    = 1'b1;
        rslt_pc    = pc;
        rslt_taken = t;
        step();
        rslt_en    = 1'b0;
    endtask

    task automatic predict(input string tag, input logic [14:0] pc, input logic exp);
        pred_en = 1'b1;
        pred_pc = pc;
        #1;
        check(tag, pred_taken, exp);
        pred_en = 1'b0;
    endtask

    // Sweep with taken updates and lookups hammering the predictor throughout.
    task automatic run_sweep(input string tag);
        pred_en    = 1'b1;
        pred_pc    = 15'h0300;
        rslt_en    = 1'b1;
        rslt_pc    = 15'h0300;
        rslt_taken = 1'b1;
        for (int i = 1; i < SWEEP; i++) begin
            step();
            if (i == 1 || i == SWEEP / 2) check({tag, "_pred_init"}, pred_taken, 1'b0);
        end
        check({tag, "_done_lo"}, init_done, 1'b0);
        check({tag, "_pred_last"}, pred_taken, 1'b0);
        step();
        rslt_en = 1'b0;
        pred_en = 1'b0;
        check({tag, "_done_hi"}, init_done, 1'b1);
    endtask

    task automatic set_hist(input logic [7:0] h);
        for (int i = 7; i >= 0; i--) update(15'h0000, h[i]);
    endtask

    initial begin
        reset      = 1'b1;
        pred_en    = 1'b0;
        pred_pc    = '0;
        rslt_en    = 1'b0;
        rslt_pc    = '0;
        rslt_taken = 1'b0;
        step();
        reset = 1'b0;
        check("rst_done", init_done, 1'b0);
        predict("rst_pred", 15'h0300, 1'b0);

        run_sweep("sweep1");
        predict("post_init", 15'h0300, 1'b0);
        update(15'h0300, 1'b0);
        predict("init_ignored", 15'h0300, 1'b0);

`ifndef PREDICTOR_GSHARE_EN
        repeat (3) update(15'h0040, 1'b1);
        predict("sat_up3", 15'h0040, 1'b1);
        predict("neighbor", 15'h0041, 1'b0);
        predict("alias_hi_pc", 15'h0440, 1'b1);
        repeat (5) update(15'h0040, 1'b1);
        update(15'h0040, 1'b0);
        predict("sat_top_nt1", 15'h0040, 1'b1);
        update(15'h0040, 1'b0);
        predict("nt2", 15'h0040, 1'b0);
        repeat (4) update(15'h0040, 1'b0);
        update(15'h0040, 1'b1);
        predict("no_wrap", 15'h0040, 1'b0);
        update(15'h0040, 1'b1);
        predict("recover", 15'h0040, 1'b1);

        pred_en    = 1'b1;
        pred_pc    = 15'h0200;
        rslt_en    = 1'b1;
        rslt_pc    = 15'h0200;
        rslt_taken = 1'b1;
        #1;
        check("hazard_same", pred_taken, 1'b0);
        step();
        rslt_en = 1'b0;
        check("hazard_next", pred_taken, 1'b1);
        pred_en = 1'b0;

        repeat (2) update(15'h0500, 1'b1);
        predict("pre_reset", 15'h0500, 1'b1);
        rslt_en    = 1'b1;
        rslt_pc    = 15'h0500;
        rslt_taken = 1'b1;
        reset      = 1'b1;
        step();
        reset   = 1'b0;
        rslt_en = 1'b0;
        check("reset_drop", init_done, 1'b0);
        run_sweep("sweep2");
        predict("reset_cleared", 15'h0500, 1'b0);
        predict("reset_cleared_b", 15'h0040, 1'b0);
`else
        set_hist(8'hB2);
        update(15'h0100, 1'b1);
        update(15'h0100, 1'b1);
        set_hist(8'hB2);
        predict("gs_hist_b2", 15'h0100, 1'b1);

        pred_en    = 1'b1;
        pred_pc    = 15'h0100;
        rslt_en    = 1'b1;
        rslt_pc    = 15'h0000;
        rslt_taken = 1'b0;
        #1;
        check("gs_pre_shift", pred_taken, 1'b1);
        step();
        rslt_en = 1'b0;
        pred_en = 1'b0;
        repeat (7) update(15'h0000, 1'b0);
        predict("gs_hist_00", 15'h0100, 1'b0);
        predict("gs_direct", 15'h01B2, 1'b1);

        set_hist(8'hB2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("gs_reset_drop", init_done, 1'b0);
        run_sweep("gs_sweep2");
        predict("gs_reset_ghr", 15'h0100, 1'b0);
        predict("gs_reset_tbl", 15'h01B2, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
